// File: rtl/apb_multi_pkg.sv
// Shared types and constants for the multi-requester APB master bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_multi_pkg;

    // Transfer sequencing: IDLE arbitrates, SETUP drives psel, ACCESS waits for pready.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Widest supported APB data bus; narrower buses use the low bits of the record.
    localparam int MAX_DATA_W  = 32;

    // Counter width for the default wait-state limit.
    localparam int DEF_TIMEOUT = 16;
    localparam int CNT_W       = $clog2(DEF_TIMEOUT + 1);

    // Completion record handed back to the owning channel.
    typedef struct packed {
        logic [MAX_DATA_W-1:0] rdata;
        logic                  error;
    } apb_rsp_t;

    // Counter width for an arbitrary wait-state limit.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: req vector + enable in, one-hot grant out.
// Latency: combinational grant; the pointer updates on the clock edge after a grant.
// Backpressure: none; en=0 suppresses every grant and freezes the pointer.
//
// Ports:
//   clk, rstn  clock and synchronous active-low reset
//   req        per-channel request
//   en         arbitration enable
//   grant      one-hot grant (all zero when en=0 or no request)
module apb_rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    output logic [NUM_CH-1:0] grant
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // ptr_q holds the channel where the next search starts, i.e. last_grant+1.
    // Resetting it to 0 makes channel 0 win first after reset.
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             found;
    int               idx;
    int               nxt;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        nxt   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (en && !found && req[idx[PTR_W-1:0]]) begin
                found                  = 1'b1;
                grant[idx[PTR_W-1:0]]  = 1'b1;
                nxt                    = idx + 1;
                if (nxt >= NUM_CH) begin
                    nxt = 0;
                end
                ptr_d = nxt[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/apb_multi_master.sv
// APB master bridge: NUM_CH local requesters share one APB bus via round-robin.
// Latency: accept at T, SETUP T+1, ACCESS T+2.., one-cycle response the cycle after ACCESS ends.
// Backpressure: cmd_ready pulses only in IDLE; responses have no backpressure.
//
// Optional feature macro: APB_WSTRB_EN adds cmd_strb / pstrb (pstrb forced to 0 on reads).
//
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready            per-channel request handshake (ready is a one-hot pulse)
//   cmd_write/cmd_addr/cmd_wdata   per-channel command fields, channel i at [i*W +: W]
//   rsp_valid/rsp_rdata/rsp_error  one-hot, one-cycle completion with shared data/error
//   paddr/psel/penable/pwrite/pwdata/prdata/pready/pslverr  APB bus
module apb_multi_master
    import apb_multi_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_CH-1:0]          cmd_valid,
    output logic [NUM_CH-1:0]          cmd_ready,
    input  logic [NUM_CH-1:0]          cmd_write,
    input  logic [NUM_CH*ADDR_W-1:0]   cmd_addr,
    input  logic [NUM_CH*DATA_W-1:0]   cmd_wdata,
`ifdef APB_WSTRB_EN
    input  logic [NUM_CH*DATA_W/8-1:0] cmd_strb,
`endif
    output logic [NUM_CH-1:0]          rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_error,
    output logic [ADDR_W-1:0]          paddr,
    output logic                       psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [DATA_W-1:0]          pwdata,
`ifdef APB_WSTRB_EN
    output logic [DATA_W/8-1:0]        pstrb,
`endif
    input  logic [DATA_W-1:0]          prdata,
    input  logic                       pready,
    input  logic                       pslverr
);

    localparam int CW = cnt_width(TIMEOUT);

    apb_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_CH-1:0]   owner_q, owner_d;
    logic [NUM_CH-1:0]   rsp_vld_q, rsp_vld_d;
    apb_rsp_t            rsp_q, rsp_d;

    logic [NUM_CH-1:0]   grant;
    logic                arb_en;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;

`ifdef APB_WSTRB_EN
    logic [DATA_W/8-1:0] pstrb_q, pstrb_d;
    logic [DATA_W/8-1:0] sel_strb;
`endif

    // Arbitration only happens in IDLE and never while reset is asserted, so
    // cmd_ready stays 0 during reset even with requests pending.
    assign arb_en = rstn && (state_q == IDLE);

    apb_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .req   (cmd_valid),
        .en    (arb_en),
        .grant (grant)
    );

    // Pick the granted channel's command fields (grant is one-hot or zero).
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
`ifdef APB_WSTRB_EN
        sel_strb  = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_addr  = cmd_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = cmd_wdata[i*DATA_W +: DATA_W];
                sel_write = cmd_write[i];
`ifdef APB_WSTRB_EN
                sel_strb  = cmd_strb[i*(DATA_W/8) +: (DATA_W/8)];
`endif
            end
        end
    end

    // Next-state and datapath. APB address/data/direction regs load only on a
    // grant, which keeps them stable for the whole SETUP/ACCESS window.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        owner_d   = owner_q;
        rsp_vld_d = '0;
        rsp_d     = '0;
`ifdef APB_WSTRB_EN
        pstrb_d   = pstrb_q;
`endif
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    paddr_d  = sel_addr;
                    pwrite_d = sel_write;
                    pwdata_d = sel_wdata;
                    owner_d  = grant;
`ifdef APB_WSTRB_EN
                    // APB4: strobes must be low on reads.
                    pstrb_d  = sel_write ? sel_strb : '0;
`endif
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_vld_d   = owner_q;
                    rsp_d.rdata = pwrite_q ? '0 : MAX_DATA_W'(prdata);
                    rsp_d.error = pslverr;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Wait-state limit reached: abandon the transfer with an error.
                    rsp_vld_d   = owner_q;
                    rsp_d.error = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            owner_q   <= '0;
            rsp_vld_q <= '0;
            rsp_q     <= '0;
`ifdef APB_WSTRB_EN
            pstrb_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            owner_q   <= owner_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_q     <= rsp_d;
`ifdef APB_WSTRB_EN
            pstrb_q   <= pstrb_d;
`endif
        end
    end

    assign cmd_ready = grant;
    assign psel      = (state_q != IDLE);
    assign penable   = (state_q == ACCESS);
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
`ifdef APB_WSTRB_EN
    assign pstrb     = pstrb_q;
`endif
    assign rsp_valid = rsp_vld_q;
    assign rsp_rdata = rsp_q.rdata[DATA_W-1:0];
    assign rsp_error = rsp_q.error;

endmodule

// File: tb/tb_apb_multi_master.sv
// Self-checking bench for apb_multi_master (NUM_CH=4, 32-bit, TIMEOUT=16).
// Stimulus pushes expected completions into a queue; a monitor pops on rsp_valid.
// Timing/APB-phase checks are made inline by the stimulus on the falling edge.
module tb_apb_multi_master;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   cmd_valid, cmd_ready, cmd_write, rsp_valid;
    logic [127:0] cmd_addr, cmd_wdata;
    logic [31:0]  rsp_rdata, paddr, pwdata, prdata;
    logic         rsp_error, psel, penable, pwrite, pready, pslverr;
`ifdef APB_WSTRB_EN
    logic [15:0]  cmd_strb;
    logic [3:0]   pstrb;
    logic [3:0]   drv_strb;
`endif

    typedef struct {
        int          ch;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    apb_multi_master #(
        .NUM_CH  (4),
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
`ifdef APB_WSTRB_EN
        .cmd_strb  (cmd_strb),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
`ifdef APB_WSTRB_EN
        .pstrb     (pstrb),
`endif
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Response monitor: every completion must match the oldest expected entry.
    always @(negedge clk) begin
        if (mon_en && (rsp_valid !== 4'b0000)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual=%b required=none", rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_valid_onehot", 64'(rsp_valid), 64'd1 << mon_e.ch);
                chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                chk("rsp_error", 64'(rsp_error), 64'(mon_e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer on one channel, starting just after a clock edge with the DUT in IDLE.
    // waits = ACCESS cycles with pready=0 before pready=1; tmo = never raise pready.
    task automatic xfer(input int ch, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits,
                        input logic [31:0] rdat, input bit err, input bit tmo);
        exp_t e;
        int   n;
        cmd_valid              = 4'b0001 << ch;
        cmd_write[ch]          = wr;
        cmd_addr[ch*32 +: 32]  = addr;
        cmd_wdata[ch*32 +: 32] = wdata;
`ifdef APB_WSTRB_EN
        cmd_strb[ch*4 +: 4]    = drv_strb;
`endif
        @(negedge clk);
        chk("cmd_ready_accept", 64'(cmd_ready), 64'd1 << ch);
        e.ch    = ch;
        e.rdata = (wr || tmo) ? 32'h0 : rdat;
        e.err   = tmo ? 1'b1 : err;
        sb.push_back(e);
        tick();
        // SETUP: pready/pslverr here must be ignored.
        cmd_valid = 4'b0000;
        pready    = 1'b1;
        pslverr   = 1'b1;
        @(negedge clk);
        chk("setup_psel", 64'(psel), 64'd1);
        chk("setup_penable", 64'(penable), 64'd0);
        chk("setup_paddr", 64'(paddr), 64'(addr));
        chk("setup_pwrite", 64'(pwrite), 64'(wr));
        if (wr) chk("setup_pwdata", 64'(pwdata), 64'(wdata));
`ifdef APB_WSTRB_EN
        chk("setup_pstrb", 64'(pstrb), wr ? 64'(drv_strb) : 64'd0);
`endif
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        n = tmo ? 16 : waits + 1;
        for (int i = 0; i < n; i++) begin
            prdata = rdat;
            if (!tmo && i == waits) begin
                pready  = 1'b1;
                pslverr = err;
            end
            @(negedge clk);
            chk("access_psel_penable", {62'd0, psel, penable}, 64'd3);
            chk("access_paddr_stable", 64'(paddr), 64'(addr));
            tick();
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
        @(negedge clk);
        chk("end_psel_penable", {62'd0, psel, penable}, 64'd0);
        chk("rsp_timing", 64'(rsp_valid), 64'd1 << ch);
        tick();
    endtask

    int order[5];
    int n_gr;

    initial begin
        order     = '{0, 1, 2, 3, 0};
        rstn      = 1'b0;
        cmd_valid = '0;
        cmd_write = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
`ifdef APB_WSTRB_EN
        cmd_strb  = '0;
        drv_strb  = 4'hF;
`endif
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_error", 64'(rsp_error), 64'd0);
        tick();
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Ch0 write, immediate pready.
        xfer(0, 1'b1, 32'h10, 32'hA5A5_0001, 0, 32'h0, 1'b0, 1'b0);
        // Ch2 read, three wait states.
        xfer(2, 1'b0, 32'h20, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);
        // Ch1 read with slave error.
        xfer(1, 1'b0, 32'h30, 32'h0, 0, 32'h5555_AAAA, 1'b1, 1'b0);
        // Ch3 read, pready never comes: timeout, rdata forced to 0 despite prdata.
        xfer(3, 1'b0, 32'h40, 32'h0, 0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        // FSM back in IDLE: a normal write right after the timeout.
        xfer(3, 1'b1, 32'h44, 32'h0BAD_F00D, 1, 32'h0, 1'b0, 1'b0);

        // Round-robin: all channels request continuously from reset.
        rstn      = 1'b0;
        cmd_valid = 4'hF;
        cmd_write = 4'h0;
        pready    = 1'b1;
        prdata    = 32'h1234_5678;
        tick();
        tick();
        @(negedge clk);
        chk("rst_cmd_ready_gated", 64'(cmd_ready), 64'd0);
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{ch: order[k], rdata: 32'h1234_5678, err: 1'b0});
        end
        tick();
        rstn = 1'b1;
        n_gr = 0;
        for (int c = 0; c < 40 && n_gr < 5; c++) begin
            @(negedge clk);
            if (cmd_ready != 4'b0000) begin
                chk($sformatf("rr_grant%0d", n_gr), 64'(cmd_ready), 64'd1 << order[n_gr]);
                n_gr++;
            end
        end
        chk("rr_grant_count", 64'(n_gr), 64'd5);
        tick();
        cmd_valid = 4'h0;
        repeat (4) tick();
        pready = 1'b0;
        prdata = 32'h0;

        // Reset in the middle of ACCESS: bus drops, no completion.
        cmd_valid        = 4'b1000;
        cmd_write[3]     = 1'b1;
        cmd_addr[96 +: 32] = 32'h50;
        tick();
        cmd_valid = 4'b0000;
        tick();
        tick();
        rstn = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst_psel_penable", {62'd0, psel, penable}, 64'd0);
        chk("midrst_paddr", 64'(paddr), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        rstn = 1'b1;
        tick();

`ifdef APB_WSTRB_EN
        drv_strb = 4'b0011;
        xfer(0, 1'b1, 32'h60, 32'h0000_BEEF, 0, 32'h0, 1'b0, 1'b0);
        drv_strb = 4'b1111;
        xfer(1, 1'b0, 32'h64, 32'h0, 0, 32'hCAFE_0001, 1'b0, 1'b0);
`endif

        repeat (5) tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
